alu_result_stage: RTL and testbench

//  Downstream capture/sequencing stage for the combinational ALU.
//  - Latches an issued opcode and drives it onto the ALU select lines.
//  - Waits a per-op settle time so the deep mul/div paths can settle.
//  - Registers ZHigh/ZLow into the Z result registers.
//  - Presents the result to the bus/HI-LO writeback with a valid/ready handshake.

---
 rtl/alu_result_stage_pkg.sv | 17 +
 rtl/alu_result_stage_settle_cnt.sv | 34 +++
 rtl/alu_result_stage.sv | 143 ++++++++++++++
 tb/tb_alu_result_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_stage_pkg.sv
// Shared ALU opcode constants and result-stage FSM state encodings.
// The ALU select decode uses the same opcode values.
package alu_result_stage_pkg;

  localparam int ALU_AND     = 0;
  localparam int ALU_OR      = 1;
  localparam int ALU_ADD     = 11;
  localparam int ALU_SUB     = 12;
  localparam int ALU_MUL     = 13;
  localparam int ALU_DIV     = 14;
  localparam int ALU_OP_LAST = 14;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

endpackage

// File: rtl/alu_result_stage_settle_cnt.sv
// Settle-time counter: loads a cycle count, decrements toward zero, flags zero.
module alu_settle_cnt #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alu_result_stage.sv
// ALU capture stage: latch op, wait per-op settle time, register Z, hand off via valid/ready.
// Defining ALU_FLAGS_EN adds registered flag_z/flag_n outputs.
module alu_result_stage
  import alu_result_stage_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    SEL_WIDTH  = 16,
  parameter int                    MUL_CYCLES = 2,
  parameter int                    DIV_CYCLES = 4,
  parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  start,
  input  logic [SEL_WIDTH-1:0]  op_in,
  output logic [SEL_WIDTH-1:0]  alu_sel,
  input  logic [DATA_WIDTH-1:0] zhigh_in,
  input  logic [DATA_WIDTH-1:0] zlow_in,
  output logic                  busy,
  output logic                  z_valid,
  input  logic                  z_ready,
  output logic [DATA_WIDTH-1:0] z_high,
  output logic [DATA_WIDTH-1:0] z_low,
  output logic                  z_hilo,
`ifdef ALU_FLAGS_EN
  output logic                  flag_z,
  output logic                  flag_n,
`endif
  output logic                  z_err
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  logic [1:0]            state_q, state_d;
  logic [SEL_WIDTH-1:0]  op_q, op_d;
  logic [DATA_WIDTH-1:0] z_high_q, z_low_q;
  logic                  z_hilo_q, z_err_q;
  logic                  accept, capture, leave_hold, cnt_zero;
  logic                  op_is_mul, op_is_hilo;
  logic [CNT_W-1:0]      settle_n;

  always_comb begin
    settle_n = '0;
    if (op_in == SEL_WIDTH'(ALU_MUL)) begin
      settle_n = CNT_W'(MUL_CYCLES);
    end else if (op_in == SEL_WIDTH'(ALU_DIV)) begin
      settle_n = CNT_W'(DIV_CYCLES);
    end
  end

  // A new op can be accepted from IDLE, or from HOLD on the same edge the result is taken.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      S_IDLE: accept = start;
      S_WAIT: begin
        if (cnt_zero) begin
          capture = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (z_ready) begin
          state_d = S_IDLE;
          accept  = start;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d = S_WAIT;
      op_d    = op_in;
    end
  end

  assign leave_hold = (state_q == S_HOLD) && z_ready;
  assign op_is_mul  = (op_q == SEL_WIDTH'(ALU_MUL));
  assign op_is_hilo = op_is_mul || (op_q == SEL_WIDTH'(ALU_DIV));

  alu_settle_cnt #(
    .WIDTH (CNT_W)
  ) u_settle_cnt (
    .clk_i      (clock),
    .rst_i      (clear),
    .load_i     (accept),
    .load_val_i (settle_n),
    .dec_i      (state_q == S_WAIT),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      z_high_q <= INIT;
      z_low_q  <= INIT;
      z_hilo_q <= 1'b0;
      z_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (capture) begin
        z_high_q <= zhigh_in;
        z_low_q  <= zlow_in;
        z_hilo_q <= op_is_hilo;
        z_err_q  <= (op_q > SEL_WIDTH'(ALU_OP_LAST));
      end else if (leave_hold) begin
        z_hilo_q <= 1'b0;
        z_err_q  <= 1'b0;
      end
    end
  end

`ifdef ALU_FLAGS_EN
  logic flag_z_q, flag_n_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
    end else if (capture) begin
      flag_z_q <= op_is_hilo ? ({zhigh_in, zlow_in} == '0) : (zlow_in == '0);
      flag_n_q <= op_is_mul ? zhigh_in[DATA_WIDTH-1] : zlow_in[DATA_WIDTH-1];
    end
  end

  assign flag_z = flag_z_q;
  assign flag_n = flag_n_q;
`endif

  assign alu_sel = op_q;
  assign busy    = (state_q != S_IDLE);
  assign z_valid = (state_q == S_HOLD);
  assign z_high  = z_high_q;
  assign z_low   = z_low_q;
  assign z_hilo  = z_hilo_q;
  assign z_err   = z_err_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed ops, expected results queued at issue.
module tb_alu_result_stage;

  localparam logic [31:0] INIT_V = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        clear, start, z_ready;
  logic [15:0] op_in, alu_sel;
  logic [31:0] zhigh_in, zlow_in, z_high, z_low;
  logic        busy, z_valid, z_hilo, z_err;
`ifdef ALU_FLAGS_EN
  logic        flag_z, flag_n;
`endif

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hilo;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  alu_result_stage #(
    .DATA_WIDTH (32),
    .SEL_WIDTH  (16),
    .MUL_CYCLES (2),
    .DIV_CYCLES (4),
    .INIT       (INIT_V)
  ) dut (
    .clock    (clock),
    .clear    (clear),
    .start    (start),
    .op_in    (op_in),
    .alu_sel  (alu_sel),
    .zhigh_in (zhigh_in),
    .zlow_in  (zlow_in),
    .busy     (busy),
    .z_valid  (z_valid),
    .z_ready  (z_ready),
    .z_high   (z_high),
    .z_low    (z_low),
    .z_hilo   (z_hilo),
`ifdef ALU_FLAGS_EN
    .flag_z   (flag_z),
    .flag_n   (flag_n),
`endif
    .z_err    (z_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [15:0] op, input logic [31:0] hi, input logic [31:0] lo,
                       input bit push, input bit hilo, input bit err);
    exp_t e;
    start    = 1'b1;
    op_in    = op;
    zhigh_in = hi;
    zlow_in  = lo;
    if (push) begin
      e.hi = hi; e.lo = lo; e.hilo = hilo; e.err = err;
      sb.push_back(e);
    end
    step();
    start = 1'b0;
  endtask

  // Monitor: a handshake is visible on the falling edge before the accepting rising edge.
  always @(negedge clock) begin
    exp_t e;
    if (!clear && z_valid && z_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: result presented with no expected entry, z_low=%h", z_low);
      end else begin
        e = sb.pop_front();
        check("sb_z_high", 64'(z_high), 64'(e.hi));
        check("sb_z_low",  64'(z_low),  64'(e.lo));
        check("sb_z_hilo", 64'(z_hilo), 64'(e.hilo));
        check("sb_z_err",  64'(z_err),  64'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear = 1'b1; start = 1'b0; z_ready = 1'b1;
    op_in = '0; zhigh_in = '0; zlow_in = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_busy",    64'(busy),    64'd0);
    check("rst_z_valid", 64'(z_valid), 64'd0);
    check("rst_z_high",  64'(z_high),  64'(INIT_V));
    check("rst_z_low",   64'(z_low),   64'(INIT_V));
    check("rst_alu_sel", 64'(alu_sel), 64'd0);
    check("rst_z_hilo",  64'(z_hilo),  64'd0);
    check("rst_z_err",   64'(z_err),   64'd0);
    clear = 1'b0;
    step();

    // 1: add, single-cycle valid two edges after start
    issue(16'd11, 32'h0, 32'h5, 1'b1, 1'b0, 1'b0);
    check("t1_busy_wait",  64'(busy),    64'd1);
    check("t1_valid_wait", 64'(z_valid), 64'd0);
    check("t1_alu_sel",    64'(alu_sel), 64'd11);
    step();
    check("t1_valid", 64'(z_valid), 64'd1);
    step();
    check("t1_valid_gone", 64'(z_valid), 64'd0);
    check("t1_busy_idle",  64'(busy),    64'd0);
    check("t1_z_low_kept", 64'(z_low),   64'h5);

    // 2: mul, held under backpressure, start ignored
    z_ready = 1'b0;
    issue(16'd13, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("t2_valid_early", 64'(z_valid), 64'd0);
      check("t2_busy_wait",   64'(busy),    64'd1);
      step();
    end
    check("t2_valid_early", 64'(z_valid), 64'd0);
    step();
    check("t2_valid", 64'(z_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; op_in = 16'd0; zhigh_in = 32'hFFFF_FFFF; zlow_in = 32'hFFFF_FFFF;
      step();
      check("t2_hold_valid", 64'(z_valid), 64'd1);
      check("t2_hold_busy",  64'(busy),    64'd1);
      check("t2_hold_data",  {z_high, z_low}, 64'h0000_0001_8000_0000);
      check("t2_hold_sel",   64'(alu_sel), 64'd13);
      check("t2_hold_hilo",  64'(z_hilo),  64'd1);
    end
    start = 1'b0;
    z_ready = 1'b1;
    step();
    check("t2_released", 64'(z_valid), 64'd0);
    check("t2_hilo_clr", 64'(z_hilo),  64'd0);

    // 3: div aborted by clear, then a clean restart
    issue(16'd14, 32'h7, 32'h9, 1'b0, 1'b1, 1'b0);
    step();
    clear = 1'b1;
    #1;
    check("t3_busy",    64'(busy),    64'd0);
    check("t3_valid",   64'(z_valid), 64'd0);
    check("t3_z_high",  64'(z_high),  64'(INIT_V));
    check("t3_z_low",   64'(z_low),   64'(INIT_V));
    check("t3_alu_sel", 64'(alu_sel), 64'd0);
    step();
    clear = 1'b0;
    step();
    issue(16'd12, 32'h0, 32'h3, 1'b1, 1'b0, 1'b0);
    check("t3_restart_wait", 64'(z_valid), 64'd0);
    step();
    check("t3_restart_valid", 64'(z_valid), 64'd1);
    step();

    // 4: back-to-back acceptance from HOLD
    issue(16'd13, 32'h0000_0002, 32'h0000_0010, 1'b1, 1'b1, 1'b0);
    step(); step(); step();
    check("t4_mul_valid", 64'(z_valid), 64'd1);
    issue(16'd0, 32'h0, 32'h0000_1234, 1'b1, 1'b0, 1'b0);
    check("t4_no_idle",   64'(busy),    64'd1);
    check("t4_wait",      64'(z_valid), 64'd0);
    check("t4_hilo_drop", 64'(z_hilo),  64'd0);
    check("t4_alu_sel",   64'(alu_sel), 64'd0);
    step();
    check("t4_valid2", 64'(z_valid), 64'd1);
    check("t4_hilo2",  64'(z_hilo),  64'd0);
    step();

    // 5: unsupported opcode
    issue(16'd20, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    step();
    check("t5_valid", 64'(z_valid), 64'd1);
    check("t5_err",   64'(z_err),   64'd1);
    check("t5_z_low", 64'(z_low),   64'd0);
    step();
    check("t5_err_clr", 64'(z_err), 64'd0);

`ifdef ALU_FLAGS_EN
    // 6: flags on sub
    issue(16'd12, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    step();
    check("t6_flag_n", 64'(flag_n), 64'd1);
    check("t6_flag_z", 64'(flag_z), 64'd0);
    step();
    issue(16'd12, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    check("t6_flag_z0", 64'(flag_z), 64'd1);
    check("t6_flag_n0", 64'(flag_n), 64'd0);
    step();
`endif

    step();
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
